n101_rst_sequencer: RTL and testbench

Staged reset-release controller that consumes the synchronized reset produced by the SoC reset catch-and-sync stage. It holds every downstream domain (always-on peripherals, bus fabric, core) in reset for a programmable stretch, then releases them one at a time, waiting for each stage's ready acknowledge before releasing the next. It also accepts software and watchdog reset requests and re-runs the sequence. It reports the last reset cause and a sticky acknowledge-timeout flag.

---
 rtl/n101_rst_sequencer_pkg.sv | 18 +
 rtl/n101_rst_sequencer.sv | 126 ++++++++++++
 tb/tb_n101_rst_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/n101_rst_sequencer_pkg.sv
// Shared definitions for the staged reset-release sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package n101_rst_sequencer_pkg;

  // Sequencer states; the stage being waited on is tracked separately.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Last reset cause codes; 2'b11 is reserved.
  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDG = 2'b10;

endpackage

// File: rtl/n101_rst_sequencer.sv
// Staged reset release: stretch, then release stages one by one on ack or timeout.
// Latency: stage 0 releases STRETCH edges after reset/request; next stage 1 edge after ack.
// Backpressure: none; acks gate progress, a missing ack is bounded by ACK_TIMEOUT.
module n101_rst_sequencer
  import n101_rst_sequencer_pkg::*;
#(
  parameter int NSTAGE      = 3,
  parameter int STRETCH     = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int CW          = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              test_mode,
  input  logic              sw_rst_req,
  input  logic              wdg_rst_req,
  input  logic [NSTAGE-1:0] stage_ack,
  output logic [NSTAGE-1:0] stage_rst_n,
  output logic              rst_done,
  output logic [1:0]        rst_cause,
  output logic              timeout_err
);

  localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_STAGE   = IW'(NSTAGE - 1);

  seq_state_e        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NSTAGE-1:0] stage_q, stage_d;
  logic              done_q, done_d;
  logic [1:0]        cause_q, cause_d;
  logic              terr_q, terr_d;
  logic              req;
  logic              ack_sel;

  assign req     = sw_rst_req | wdg_rst_req;
  assign ack_sel = stage_ack[idx_q];

  // Next-state, counter and output-register values; requests override the per-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    stage_d = stage_q;
    done_d  = done_q;
    cause_d = cause_q;
    terr_d  = terr_q;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == STRETCH_LAST) begin
          state_d    = ST_WAIT;
          idx_d      = '0;
          cnt_d      = '0;
          stage_d[0] = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ack_sel || (cnt_q == TIMEOUT_LAST)) begin
          // A missing ack still advances, but leaves a sticky trace.
          if (!ack_sel) begin
            terr_d = 1'b1;
          end
          cnt_d = '0;
          if (idx_q == LAST_STAGE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d          = idx_q + 1'b1;
            stage_d[idx_d] = 1'b1;
          end
        end
      end
      ST_DONE: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Requests restart the sequence from WAIT or DONE; HOLD ignores them so a
    // level request cannot keep extending the stretch. Timeout flag is not cleared.
    if ((state_q != ST_HOLD) && req) begin
      state_d = ST_HOLD;
      idx_d   = '0;
      cnt_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
      terr_d  = terr_q;
      cause_d = wdg_rst_req ? CAUSE_WDG : CAUSE_SW;
    end
  end

  // State, shared counter and registered outputs; rst_n low wins over everything.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      terr_q  <= terr_d;
    end
  end

  // Test mode hands reset control straight to rst_n; the FSM keeps running underneath.
  assign stage_rst_n = test_mode ? {NSTAGE{rst_n}} : stage_q;
  assign rst_done    = test_mode ? rst_n : done_q;
  assign rst_cause   = cause_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_n101_rst_sequencer.sv
// Directed bench for the staged reset sequencer.
// Latency: edge-accurate checks against hand-computed edge numbers.
// Backpressure: acks driven from tables and fixed sequences.
module tb_n101_rst_sequencer;

  logic       clock;
  logic       rst_n;
  logic       test_mode;
  logic       sw_rst_req;
  logic       wdg_rst_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst_n;
  logic       rst_done;
  logic [1:0] rst_cause;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int         at_edge;
    logic [2:0] ack_after;
    logic [2:0] exp_stage;
    logic       exp_done;
  } vec_t;

  vec_t por_tbl[9];

  n101_rst_sequencer #(
    .NSTAGE(3), .STRETCH(16), .ACK_TIMEOUT(8), .CW(8)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .test_mode(test_mode),
    .sw_rst_req(sw_rst_req),
    .wdg_rst_req(wdg_rst_req),
    .stage_ack(stage_ack),
    .stage_rst_n(stage_rst_n),
    .rst_done(rst_done),
    .rst_cause(rst_cause),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clock);
    edge_n++;
    #1;
  endtask

  task automatic tick_to(input int target);
    while (edge_n < target) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int k2;
    int k3;

    // POR sequence: acks return 2 cycles after each release.
    por_tbl[0] = '{15, 3'b000, 3'b000, 1'b0};
    por_tbl[1] = '{16, 3'b000, 3'b001, 1'b0};
    por_tbl[2] = '{18, 3'b001, 3'b001, 1'b0};
    por_tbl[3] = '{19, 3'b001, 3'b011, 1'b0};
    por_tbl[4] = '{21, 3'b011, 3'b011, 1'b0};
    por_tbl[5] = '{22, 3'b011, 3'b111, 1'b0};
    por_tbl[6] = '{24, 3'b111, 3'b111, 1'b0};
    por_tbl[7] = '{25, 3'b111, 3'b111, 1'b1};
    por_tbl[8] = '{26, 3'b111, 3'b111, 1'b1};

    rst_n       = 1'b0;
    test_mode   = 1'b0;
    sw_rst_req  = 1'b0;
    wdg_rst_req = 1'b0;
    stage_ack   = 3'b000;
    tick();
    tick();
    edge_n = 0;

    chk("reset_stage", 32'(stage_rst_n), 32'h0);
    chk("reset_done", 32'(rst_done), 32'h0);
    chk("reset_cause", 32'(rst_cause), 32'h0);
    chk("reset_terr", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      tick_to(por_tbl[i].at_edge);
      chk($sformatf("por_stage[%0d]", i), 32'(stage_rst_n), 32'(por_tbl[i].exp_stage));
      chk($sformatf("por_done[%0d]", i), 32'(rst_done), 32'(por_tbl[i].exp_done));
      stage_ack = por_tbl[i].ack_after;
    end
    chk("por_cause", 32'(rst_cause), 32'(2'b00));
    chk("por_terr", 32'(timeout_err), 32'h0);

    // Software reset from DONE.
    stage_ack = 3'b000;
    tick();
    sw_rst_req = 1'b1;
    tick();
    k = edge_n;
    sw_rst_req = 1'b0;
    chk("sw_stage_clr", 32'(stage_rst_n), 32'h0);
    chk("sw_done_clr", 32'(rst_done), 32'h0);
    chk("sw_cause", 32'(rst_cause), 32'(2'b01));
    tick_to(k + 15);
    chk("sw_stretch_hold", 32'(stage_rst_n), 32'h0);
    tick_to(k + 16);
    chk("sw_release0", 32'(stage_rst_n), 32'(3'b001));
    stage_ack = 3'b001;
    tick_to(k + 17);
    chk("sw_release1", 32'(stage_rst_n), 32'(3'b011));

    // Simultaneous SW and WDG during WAIT_ACK(1); requests held into HOLD are ignored.
    sw_rst_req  = 1'b1;
    wdg_rst_req = 1'b1;
    tick();
    k2 = edge_n;
    chk("both_stage_clr", 32'(stage_rst_n), 32'h0);
    chk("both_cause_wdg", 32'(rst_cause), 32'(2'b10));
    tick_to(k2 + 5);
    sw_rst_req  = 1'b0;
    wdg_rst_req = 1'b0;
    chk("hold_req_cause", 32'(rst_cause), 32'(2'b10));
    tick_to(k2 + 15);
    chk("hold_not_extended0", 32'(stage_rst_n), 32'h0);
    tick_to(k2 + 16);
    chk("hold_not_extended1", 32'(stage_rst_n), 32'(3'b001));
    tick_to(k2 + 17);
    chk("wdg_release1", 32'(stage_rst_n), 32'(3'b011));

    // Timeout on stage 1 (ack[1] held low): stage 2 releases 8 edges later.
    tick_to(k2 + 24);
    chk("to_before_stage", 32'(stage_rst_n), 32'(3'b011));
    chk("to_before_terr", 32'(timeout_err), 32'h0);
    tick_to(k2 + 25);
    chk("to_release2", 32'(stage_rst_n), 32'(3'b111));
    chk("to_terr_set", 32'(timeout_err), 32'h1);

    // Sticky timeout survives an accepted request.
    sw_rst_req = 1'b1;
    tick();
    k3 = edge_n;
    sw_rst_req = 1'b0;
    chk("to_sticky_terr", 32'(timeout_err), 32'h1);
    chk("to_sticky_cause", 32'(rst_cause), 32'(2'b01));
    chk("to_sticky_stage", 32'(stage_rst_n), 32'h0);

    // Reach WAIT_ACK(2), then rst_n together with ack[2].
    stage_ack = 3'b011;
    tick_to(k3 + 18);
    chk("w2_stage", 32'(stage_rst_n), 32'(3'b111));
    chk("w2_done", 32'(rst_done), 32'h0);
    tick_to(k3 + 19);
    rst_n     = 1'b0;
    stage_ack = 3'b111;
    tick();
    chk("rstmid_stage", 32'(stage_rst_n), 32'h0);
    chk("rstmid_done", 32'(rst_done), 32'h0);
    chk("rstmid_cause", 32'(rst_cause), 32'(2'b00));
    chk("rstmid_terr", 32'(timeout_err), 32'h0);
    rst_n     = 1'b1;
    stage_ack = 3'b000;
    tick();
    chk("post_rst_stage", 32'(stage_rst_n), 32'h0);

    // Test mode: outputs follow rst_n with no clock edge in between.
    test_mode = 1'b1;
    #1;
    chk("tm_stage_hi", 32'(stage_rst_n), 32'(3'b111));
    chk("tm_done_hi", 32'(rst_done), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("tm_stage_lo", 32'(stage_rst_n), 32'h0);
    chk("tm_done_lo", 32'(rst_done), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("tm_stage_hi2", 32'(stage_rst_n), 32'(3'b111));
    test_mode = 1'b0;
    #1;
    chk("tm_exit_stage", 32'(stage_rst_n), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
